// File: rtl/write_back_stage_pkg.sv
// write_back_stage_pkg
//   Shared constants for the write-back stage: datapath/register widths,
//   write-back source select codes, load funct3 codes and the FSM state type.
package write_back_stage_pkg;

   localparam int DATA_SIZE     = 32;
   localparam int REG_ADDR_SIZE = 5;

   // write-back source select (11 is reserved and behaves as ALU)
   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;

   // load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_t;

endpackage

// File: rtl/write_back_stage_load_extend.sv
// write_back_stage_load_extend
//   Combinational load data alignment and extension.
//   funct3   : load type (LB/LH/LW/LBU/LHU; any other code returns the word)
//   addr_low : byte offset of the access (address bits 1:0)
//   word     : raw aligned memory word
//   data     : extended result
module write_back_stage_load_extend
   import write_back_stage_pkg::*;
#(
   parameter int DATA_W = DATA_SIZE
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_low,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] data
);

   logic [3:0][7:0] bytes;
   logic [7:0]      b;
   logic [15:0]     h;

   assign bytes = word;
   assign b     = bytes[addr_low];
   // halves are selected by bit 1 only; bit 0 is ignored for halfword loads
   assign h     = addr_low[1] ? word[31:16] : word[15:0];

   always_comb begin
      data = word;
      case (funct3)
         F3_LB:   data = {{(DATA_W-8){b[7]}}, b};
         F3_LBU:  data = {{(DATA_W-8){1'b0}}, b};
         F3_LH:   data = {{(DATA_W-16){h[15]}}, h};
         F3_LHU:  data = {{(DATA_W-16){1'b0}}, h};
         F3_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/write_back_stage.sv
// write_back_stage
//   Final RV32I pipeline stage: selects the write-back source (ALU, load
//   data, PC+4) and drives a registered one-cycle register-file write pulse.
//   Loads park in WAIT_MEM, holding inReady low until memRespValid arrives.
//   Ports:
//     clk, rstN                       clock, async active-low reset
//     inValid/inReady                 MEM-stage handshake
//     inRegWrite, inRd, inWbSel,
//     inFunct3, inAddrLow,
//     inAluResult, inPcPlus4          retiring instruction fields
//     memRespValid, memRespData       data-memory load response
//     writeEnable/writeAddr/writeDate register-file write port
//     instretCount                    retired-instruction counter
//                                     (only when WB_INSTRET_EN is defined)
module write_back_stage
   import write_back_stage_pkg::*;
#(
   parameter int DATA_W = DATA_SIZE,
   parameter int REG_AW = REG_ADDR_SIZE
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              inValid,
   output logic              inReady,
   input  logic              inRegWrite,
   input  logic [REG_AW-1:0] inRd,
   input  logic [1:0]        inWbSel,
   input  logic [2:0]        inFunct3,
   input  logic [1:0]        inAddrLow,
   input  logic [DATA_W-1:0] inAluResult,
   input  logic [DATA_W-1:0] inPcPlus4,
   input  logic              memRespValid,
   input  logic [DATA_W-1:0] memRespData,
   output logic              writeEnable,
   output logic [REG_AW-1:0] writeAddr,
   output logic [DATA_W-1:0] writeDate
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]       instretCount
`endif
);

   wb_state_t         state_q, state_d;

   // pending load context captured at the load transfer
   logic              pend_we;
   logic [REG_AW-1:0] pend_rd;
   logic [2:0]        pend_f3;
   logic [1:0]        pend_alow;

   logic              latch;
   logic              slot;     // a write-back slot happens next cycle
   logic              we_d;
   logic [REG_AW-1:0] addr_d;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] ext;

   write_back_stage_load_extend #(.DATA_W(DATA_W)) u_ext (
      .funct3   (pend_f3),
      .addr_low (pend_alow),
      .word     (memRespData),
      .data     (ext)
   );

   assign src = (inWbSel == WB_SEL_PC4) ? inPcPlus4 : inAluResult;

   always_comb begin
      state_d = state_q;
      inReady = (state_q == ST_IDLE);
      latch   = 1'b0;
      slot    = 1'b0;
      we_d    = 1'b0;
      addr_d  = writeAddr;
      data_d  = writeDate;
      case (state_q)
         ST_IDLE: begin
            if (inValid) begin
               if (inWbSel == WB_SEL_LOAD) begin
                  latch   = 1'b1;
                  state_d = ST_WAIT_MEM;
               end else begin
                  slot   = 1'b1;
                  we_d   = inRegWrite && (inRd != '0);
                  addr_d = inRd;
                  data_d = src;
               end
            end
         end
         ST_WAIT_MEM: begin
            if (memRespValid) begin
               slot    = 1'b1;
               we_d    = pend_we && (pend_rd != '0);
               addr_d  = pend_rd;
               data_d  = ext;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= ST_IDLE;
         writeEnable <= 1'b0;
         writeAddr   <= '0;
         writeDate   <= '0;
         pend_we     <= 1'b0;
         pend_rd     <= '0;
         pend_f3     <= '0;
         pend_alow   <= '0;
      end else begin
         state_q     <= state_d;
         writeEnable <= we_d;
         writeAddr   <= addr_d;
         writeDate   <= data_d;
         if (latch) begin
            pend_we   <= inRegWrite;
            pend_rd   <= inRd;
            pend_f3   <= inFunct3;
            pend_alow <= inAddrLow;
         end
      end
   end

`ifdef WB_INSTRET_EN
   // counts every retirement slot, including rd==0 and non-writing ops
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)     instretCount <= '0;
      else if (slot) instretCount <= instretCount + 64'd1;
   end
`endif

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

   logic        clk = 1'b0;
   logic        rstN;
   logic        inValid;
   logic        inReady;
   logic        inRegWrite;
   logic [4:0]  inRd;
   logic [1:0]  inWbSel;
   logic [2:0]  inFunct3;
   logic [1:0]  inAddrLow;
   logic [31:0] inAluResult;
   logic [31:0] inPcPlus4;
   logic        memRespValid;
   logic [31:0] memRespData;
   logic        writeEnable;
   logic [4:0]  writeAddr;
   logic [31:0] writeDate;
`ifdef WB_INSTRET_EN
   logic [63:0] instretCount;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   int exp_ir = 0;

   always #5 clk = ~clk;

   write_back_stage dut (
      .clk          (clk),
      .rstN         (rstN),
      .inValid      (inValid),
      .inReady      (inReady),
      .inRegWrite   (inRegWrite),
      .inRd         (inRd),
      .inWbSel      (inWbSel),
      .inFunct3     (inFunct3),
      .inAddrLow    (inAddrLow),
      .inAluResult  (inAluResult),
      .inPcPlus4    (inPcPlus4),
      .memRespValid (memRespValid),
      .memRespData  (memRespData),
      .writeEnable  (writeEnable),
      .writeAddr    (writeAddr),
      .writeDate    (writeDate)
`ifdef WB_INSTRET_EN
      ,
      .instretCount (instretCount)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [1:0] alow,
                        input logic [31:0] alu, input logic [31:0] pc4);
      inValid     = 1'b1;
      inRegWrite  = rw;
      inRd        = rd;
      inWbSel     = sel;
      inFunct3    = f3;
      inAddrLow   = alow;
      inAluResult = alu;
      inPcPlus4   = pc4;
   endtask

   // non-load op: one transfer, write visible one cycle later
   task automatic op(input string tag, input logic rw, input logic [4:0] rd,
                     input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc4,
                     input logic exp_we, input logic [31:0] exp_d);
      drive(rw, rd, sel, 3'b000, 2'b00, alu, pc4);
      step();
      inValid = 1'b0;
      exp_ir++;
      chk({tag, ".we"},   writeEnable, exp_we);
      chk({tag, ".addr"}, writeAddr, rd);
      chk({tag, ".data"}, writeDate, exp_d);
   endtask

   // load: transfer, then dly stall cycles, response in the last stall cycle
   task automatic ld(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                     input logic [1:0] alow, input logic [31:0] word, input int dly,
                     input logic exp_we, input logic [31:0] exp_d);
      drive(1'b1, rd, 2'b01, f3, alow, 32'hBAD0_BAD0, 32'hBAD1_BAD1);
      step();
      inValid = 1'b0;
      for (int i = 0; i < dly; i++) begin
         chk({tag, ".stall_rdy"}, inReady, 1'b0);
         chk({tag, ".stall_we"},  writeEnable, 1'b0);
         if (i == dly - 1) begin
            memRespValid = 1'b1;
            memRespData  = word;
         end
         step();
         memRespValid = 1'b0;
      end
      exp_ir++;
      chk({tag, ".we"},   writeEnable, exp_we);
      chk({tag, ".addr"}, writeAddr, rd);
      chk({tag, ".data"}, writeDate, exp_d);
      chk({tag, ".rdy"},  inReady, 1'b1);
   endtask

   initial begin
      rstN = 1'b0;
      inValid = 1'b0; inRegWrite = 1'b0; inRd = '0; inWbSel = '0; inFunct3 = '0;
      inAddrLow = '0; inAluResult = '0; inPcPlus4 = '0;
      memRespValid = 1'b0; memRespData = '0;
      step(); step();
      chk("rst.we",   writeEnable, 1'b0);
      chk("rst.addr", writeAddr, 5'd0);
      chk("rst.data", writeDate, 32'd0);
`ifdef WB_INSTRET_EN
      chk("rst.instret", instretCount, 64'd0);
`endif
      rstN = 1'b1;
      step();
      chk("rst.rdy", inReady, 1'b1);

      // reset while a load is pending drops it
      drive(1'b1, 5'd9, 2'b01, 3'b010, 2'b00, 32'h0, 32'h0);
      step();
      inValid = 1'b0;
      chk("rstmid.stall", inReady, 1'b0);
      rstN = 1'b0;
      #1;
      chk("rstmid.rdy_in_rst", inReady, 1'b1);
      chk("rstmid.we_in_rst",  writeEnable, 1'b0);
      step();
      rstN = 1'b1;
      step();
      memRespValid = 1'b1; memRespData = 32'h5555_AAAA;
      step();
      memRespValid = 1'b0;
      chk("rstmid.we",   writeEnable, 1'b0);
      chk("rstmid.rdy",  inReady, 1'b1);
      chk("rstmid.data", writeDate, 32'd0);
      step();
      chk("rstmid.we2",  writeEnable, 1'b0);

      // two ALU ops plus one stalled load
      op("alu5", 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678);
      chk("alu5.pulse", writeEnable, 1'b1);
      step();
      chk("hold.we",   writeEnable, 1'b0);
      chk("hold.addr", writeAddr, 5'd5);
      chk("hold.data", writeDate, 32'h1234_5678);
      op("alu0", 1'b1, 5'd0, 2'b00, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678);
      ld("lw", 5'd7, 3'b010, 2'b00, 32'hDEAD_BEEF, 3, 1'b1, 32'hDEAD_BEEF);
`ifdef WB_INSTRET_EN
      chk("instret3", instretCount, 64'd3);
`endif

      // stray response while idle is ignored
      memRespValid = 1'b1; memRespData = 32'h0BAD_F00D;
      step();
      memRespValid = 1'b0;
      chk("stray.we",   writeEnable, 1'b0);
      chk("stray.data", writeDate, 32'hDEAD_BEEF);
      chk("stray.rdy",  inReady, 1'b1);

      op("jal",   1'b1, 5'd1, 2'b10, 32'hFFFF_0000, 32'h0000_0104, 1'b1, 32'h0000_0104);
      op("rsv11", 1'b1, 5'd2, 2'b11, 32'hA5A5_5A5A, 32'h0000_0200, 1'b1, 32'hA5A5_5A5A);
      op("norw",  1'b0, 5'd3, 2'b00, 32'h0000_0033, 32'h0,         1'b0, 32'h0000_0033);

      // back-to-back ALU transfers: one write per cycle
      drive(1'b1, 5'd10, 2'b00, 3'b000, 2'b00, 32'h0000_000A, 32'h0);
      step();
      chk("b2b1.we",   writeEnable, 1'b1);
      chk("b2b1.data", writeDate, 32'h0000_000A);
      drive(1'b1, 5'd11, 2'b00, 3'b000, 2'b00, 32'h0000_000B, 32'h0);
      step();
      inValid = 1'b0;
      chk("b2b2.we",   writeEnable, 1'b1);
      chk("b2b2.addr", writeAddr, 5'd11);
      chk("b2b2.data", writeDate, 32'h0000_000B);
      exp_ir += 2;

      // load extension cases
      ld("lb3",   5'd3,  3'b000, 2'd3, 32'h80FF_0011, 1, 1'b1, 32'hFFFF_FF80);
      ld("lbu3",  5'd4,  3'b100, 2'd3, 32'h80FF_0011, 1, 1'b1, 32'h0000_0080);
      ld("lb0",   5'd6,  3'b000, 2'd0, 32'h80FF_0011, 2, 1'b1, 32'h0000_0011);
      ld("lb2",   5'd8,  3'b000, 2'd2, 32'h80FF_0011, 1, 1'b1, 32'hFFFF_FFFF);
      ld("lhu2",  5'd12, 3'b101, 2'd2, 32'h8001_7FFF, 1, 1'b1, 32'h0000_8001);
      ld("lh0",   5'd13, 3'b001, 2'd0, 32'h8001_7FFF, 1, 1'b1, 32'h0000_7FFF);
      ld("lh2",   5'd14, 3'b001, 2'd2, 32'h8001_7FFF, 1, 1'b1, 32'hFFFF_8001);
      ld("lw3",   5'd15, 3'b010, 2'd3, 32'h1357_9BDF, 1, 1'b1, 32'h1357_9BDF);
      ld("f3odd", 5'd16, 3'b111, 2'd1, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D);
      ld("ldx0",  5'd0,  3'b010, 2'd0, 32'h7777_7777, 1, 1'b0, 32'h7777_7777);
      step();
      chk("end.we", writeEnable, 1'b0);
`ifdef WB_INSTRET_EN
      chk("instret.end", instretCount, 64'(exp_ir));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final pipeline stage of the RV32I core; this block is the writer side of the register file's write port (writeEnable/writeAddr/writeDate).
- Accepts retiring instructions from the MEM stage and selects the write-back source: ALU result, load data or PC+4.
- For loads, waits for the data-memory response, then sign- or zero-extends it.
- Drives a registered, single-cycle register-file write pulse and back-pressures MEM while a load is outstanding.

Parameters:
- DATA_W, 32, datapath width (equals `DataSize).
- REG_AW, 5, register address width (equals `RegAddrSize).

Ports:
- clk  input  1  core clock, rising edge.
- rstN  input  1  asynchronous, active-low reset.
- inValid  input  1  MEM stage presents an instruction.
- inReady  output  1  stage can accept; transfer occurs when inValid && inReady.
- inRegWrite  input  1  instruction writes rd.
- inRd  input  REG_AW  destination register.
- inWbSel  input  2  source select: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU).
- inFunct3  input  3  load type.
- inAddrLow  input  2  load byte offset (address bits 1:0).
- inAluResult  input  DATA_W  ALU result.
- inPcPlus4  input  DATA_W  link value.
- memRespValid  input  1  load data valid, one-cycle pulse.
- memRespData  input  DATA_W  raw aligned 32-bit memory word.
- writeEnable  output  1  register-file write strobe.
- writeAddr  output  REG_AW  register-file rd.
- writeDate  output  DATA_W  register-file write data.

Behaviour:
- Reset (rstN low, async): FSM IDLE; writeEnable=0, writeAddr=0, writeDate=0; inReady=1 after deassertion.
- FSM has two states.
  - IDLE: inReady=1.
  - WAIT_MEM: inReady=0; a load is pending.
- IDLE, transfer with inWbSel!=01: next cycle writeEnable=inRegWrite && (inRd!=0), writeAddr=inRd, writeDate=selected source. Latency is 1 cycle; stay IDLE.
- IDLE, transfer with inWbSel==01: latch rd, regWrite, funct3 and addrLow; go to WAIT_MEM. The load response is never accepted in the same cycle as its request.
- WAIT_MEM with memRespValid=1: next cycle writeEnable/addr/data are driven from the extended load data; return to IDLE. inReady rises in that same next cycle.
- memRespValid while in IDLE is ignored.
- Load extension by funct3:
  - 000 LB: byte at inAddrLow, sign-extended.
  - 100 LBU: byte at inAddrLow, zero-extended.
  - 001 LH: half selected by addrLow[1], sign-extended.
  - 101 LHU: half selected by addrLow[1], zero-extended.
  - 010 LW, and any other code: full word; addrLow ignored.
- rd==0 never produces writeEnable=1 (x0 hardwired); writeAddr/writeDate still update.
- writeEnable is a one-cycle pulse. On cycles with no write, writeEnable=0 and writeAddr/writeDate hold their last values.
- Back-to-back non-load transfers produce back-to-back writes, one per cycle.
- Reset asserted during WAIT_MEM drops the pending load, with no write. A later stray memRespValid is ignored.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output port instretCount, 64 bits, reset 0, wraps modulo 2^64.
  - Increments by 1 in the same cycle the retiring instruction's write-back slot occurs: cycle after transfer for non-loads, cycle after memRespValid for loads.
  - Counts regardless of inRegWrite or rd==0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared constants live in define.v: `DataSize, `RegAddrSize, WB_SEL_ALU/LOAD/PC4 codes, and load funct3 codes (LB, LH, LW, LBU, LHU).
- One natural sub-module: load_extend (combinational). Inputs funct3, addrLow, word; output extended data. The FSM and write registers stay in write_back_stage.

Test Plan:
- Reset mid-operation: accept LW so the FSM enters WAIT_MEM, pulse rstN low, release, then pulse memRespValid -> no writeEnable at any point; inReady=1.
- ALU writes: ALU op rd=5, result 0x1234_5678 -> next cycle writeEnable=1, writeAddr=5, writeDate=0x12345678. Same op with rd=0 -> writeEnable=0.
- JAL link: JAL rd=1, inWbSel=10, pc4=0x0000_0104 -> writeDate=0x104 one cycle later.
- Byte loads: LB offset 3, word 0x80FF_0011 -> writeDate=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- Half loads: LHU offset 2, word 0x8001_7FFF -> writeDate=0x0000_8001. LH offset 0 -> 0x0000_7FFF.
- Load stall: LW rd=7, response 3 cycles later with 0xDEAD_BEEF -> inReady=0 for 3 cycles, then writeEnable, rd=7, data 0xDEADBEEF. A memRespValid pulse in IDLE is ignored. With WB_INSTRET_EN, two ALU ops plus one load -> instretCount=3.
